// File: rtl/y86_mem_pkg.sv
// Shared definitions for the Y86 memory-stage request channel (initiator and responder).
// Holds the instruction codes, memory-space encodings, FSM states and the access decoder.
package y86_mem_pkg;

  localparam logic [3:0] ICODE_RMMOVQ = 4'd4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'd5;
  localparam logic [3:0] ICODE_PUSHQ  = 4'd10;
  localparam logic [3:0] ICODE_POPQ   = 4'd11;

  localparam logic SPACE_DATA  = 1'b0;
  localparam logic SPACE_STACK = 1'b1;

  // Stall budget in REQ/WAIT before an access is abandoned (MEMREQ_TIMEOUT_EN builds only).
  localparam int TIMEOUT_CYC = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  typedef struct packed {
    logic        is_mem;
    logic        we;
    logic        space;
    logic [63:0] addr;
  } decode_t;

  // popq is the only access addressed by ValA; everything else uses ValE.
  function automatic decode_t decode_icode(input logic [3:0]  icode,
                                           input logic [63:0] val_e,
                                           input logic [63:0] val_a);
    decode_t d;
    d        = '0;
    d.addr   = val_e;
    case (icode)
      ICODE_RMMOVQ: begin
        d.is_mem = 1'b1;
        d.we     = 1'b1;
        d.space  = SPACE_DATA;
      end
      ICODE_MRMOVQ: begin
        d.is_mem = 1'b1;
        d.we     = 1'b0;
        d.space  = SPACE_DATA;
      end
      ICODE_PUSHQ: begin
        d.is_mem = 1'b1;
        d.we     = 1'b1;
        d.space  = SPACE_STACK;
      end
      ICODE_POPQ: begin
        d.is_mem = 1'b1;
        d.we     = 1'b0;
        d.space  = SPACE_STACK;
        d.addr   = val_a;
      end
      default: d.is_mem = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/y86_mem_req_ctrl.sv
// Memory-stage initiator: one valid/ready request per instruction, valid-only read response.
// Optional stall watchdog enabled by defining MEMREQ_TIMEOUT_EN.
module y86_mem_req_ctrl
  import y86_mem_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        icode,
  input  logic [63:0]       ValE,
  input  logic [63:0]       ValA,
  output logic              busy,
  output logic              done,
  output logic [63:0]       ValM,
  output logic              dmem_error,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic              mem_space,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [63:0]       mem_rdata
);

  state_t  state;
  state_t  state_nxt;
  decode_t dec;
  logic    addr_err;
  logic    issue;
  logic    timeout;

  assign dec = decode_icode(icode, ValE, ValA);

  // Full 64-bit range check so high address bits never alias into the array.
  assign addr_err = dec.is_mem && (dec.addr > 64'(DEPTH - 1));
  assign issue    = (state == IDLE) && start && dec.is_mem && !addr_err;

`ifdef MEMREQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] stall_cnt;
  logic             stalled;

  assign stalled = ((state == REQ)  && !mem_req_ready) ||
                   ((state == WAIT) && !mem_rsp_valid);
  assign timeout = stalled && (stall_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Restarted on entry to REQ and again when the read moves on to WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state == IDLE) || ((state == REQ) && mem_req_ready)) begin
      stall_cnt <= '0;
    end else if (stalled) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = issue ? REQ : DONE;
        end
      end
      REQ: begin
        if (timeout) begin
          state_nxt = DONE;
        end else if (mem_req_ready) begin
          state_nxt = mem_we ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (timeout || mem_rsp_valid) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state != IDLE);
    done          = (state == DONE);
    mem_req_valid = (state == REQ);
  end

  // Request fields are captured once at issue and held until the next issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_space <= SPACE_DATA;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (issue) begin
      mem_we    <= dec.we;
      mem_space <= dec.space;
      mem_addr  <= dec.addr[ADDR_W-1:0];
      mem_wdata <= ValA;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ValM       <= '0;
      dmem_error <= 1'b0;
    end else begin
      if (((state == IDLE) && start && addr_err) || timeout) begin
        dmem_error <= 1'b1;
      end
      if ((state == WAIT) && mem_rsp_valid) begin
        ValM <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_y86_mem_req_ctrl.sv
// Directed bench for y86_mem_req_ctrl: vector table of single accesses plus stall, back-to-back,
// reset-abort and (with MEMREQ_TIMEOUT_EN) watchdog sequences.
module tb_y86_mem_req_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] ValE;
  logic [63:0] ValA;
  logic        busy;
  logic        done;
  logic [63:0] ValM;
  logic        dmem_error;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic        mem_space;
  logic [9:0]  mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [63:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  y86_mem_req_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .icode         (icode),
    .ValE          (ValE),
    .ValA          (ValA),
    .busy          (busy),
    .done          (done),
    .ValM          (ValM),
    .dmem_error    (dmem_error),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_we        (mem_we),
    .mem_space     (mem_space),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  icode;
    logic [63:0] vale;
    logic [63:0] vala;
    logic [63:0] rdata;
    bit          exp_req;
    bit          exp_we;
    bit          exp_space;
    logic [9:0]  exp_addr;
    logic [63:0] exp_wdata;
    int          exp_done;
    logic [63:0] exp_valm;
    bit          exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Responder holds ready and rsp_valid high, so any response outside WAIT must be ignored.
  task automatic run_vec(input vec_t v, input int idx);
    int          done_cyc;
    bit          saw_req;
    logic        cap_we;
    logic        cap_space;
    logic [9:0]  cap_addr;
    logic [63:0] cap_wdata;
    done_cyc      = -1;
    saw_req       = 1'b0;
    cap_we        = 1'b0;
    cap_space     = 1'b0;
    cap_addr      = '0;
    cap_wdata     = '0;
    icode         = v.icode;
    ValE          = v.vale;
    ValA          = v.vala;
    mem_rdata     = v.rdata;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (mem_req_valid && !saw_req) begin
        saw_req   = 1'b1;
        cap_we    = mem_we;
        cap_space = mem_space;
        cap_addr  = mem_addr;
        cap_wdata = mem_wdata;
      end
      if (done) begin
        done_cyc = c;
        break;
      end
      @(negedge clk);
    end
    check($sformatf("v%0d done_cycle", idx), 64'(done_cyc), 64'(v.exp_done));
    check($sformatf("v%0d req_issued", idx), 64'(saw_req), 64'(v.exp_req));
    if (v.exp_req) begin
      check($sformatf("v%0d mem_we", idx), 64'(cap_we), 64'(v.exp_we));
      check($sformatf("v%0d mem_space", idx), 64'(cap_space), 64'(v.exp_space));
      check($sformatf("v%0d mem_addr", idx), 64'(cap_addr), 64'(v.exp_addr));
      check($sformatf("v%0d mem_wdata", idx), cap_wdata, v.exp_wdata);
    end
    check($sformatf("v%0d ValM", idx), ValM, v.exp_valm);
    check($sformatf("v%0d dmem_error", idx), 64'(dmem_error), 64'(v.exp_err));
    @(negedge clk);
    check($sformatf("v%0d done_one_cycle", idx), 64'(done), 64'd0);
    check($sformatf("v%0d idle_after", idx), 64'(busy), 64'd0);
  endtask

  initial begin
    logic [6:0] done_pat;
    int         dcyc;

    vecs[0] = '{4'd4,  64'd8,    64'd3,   64'd0,   1, 1, 0, 10'd8,    64'd3,   2, 64'd0,   0};
    vecs[1] = '{4'd5,  64'd8,    64'd77,  64'd3,   1, 0, 0, 10'd8,    64'd77,  3, 64'd3,   0};
    vecs[2] = '{4'd11, 64'd999,  64'd2,   64'd220, 1, 0, 1, 10'd2,    64'd2,   3, 64'd220, 0};
    vecs[3] = '{4'd10, 64'd1023, 64'hDEAD_BEEF_0123_4567, 64'd5, 1, 1, 1, 10'd1023,
                64'hDEAD_BEEF_0123_4567, 2, 64'd220, 0};
    vecs[4] = '{4'd5,  64'd1023, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 10'd1023, 64'd0,
                3, 64'hFFFF_FFFF_FFFF_FFFF, 0};
    vecs[5] = '{4'd0,  64'd8,    64'd3,   64'd9,   0, 0, 0, 10'd0, 64'd0, 1,
                64'hFFFF_FFFF_FFFF_FFFF, 0};
    vecs[6] = '{4'd5,  64'd1024, 64'd3,   64'd9,   0, 0, 0, 10'd0, 64'd0, 1,
                64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[7] = '{4'd4,  64'h8000_0000_0000_0008, 64'd1, 64'd9, 0, 0, 0, 10'd0, 64'd0, 1,
                64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[8] = '{4'd11, 64'd0,    64'd1024, 64'd9,  0, 0, 0, 10'd0, 64'd0, 1,
                64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[9] = '{4'd10, 64'd5,    64'd42,  64'd9,   1, 1, 1, 10'd5,    64'd42,  2,
                64'hFFFF_FFFF_FFFF_FFFF, 1};

    rst           = 1'b1;
    start         = 1'b0;
    icode         = '0;
    ValE          = '0;
    ValA          = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst ValM", ValM, 64'd0);
    check("rst dmem_error", 64'(dmem_error), 64'd0);
    check("rst mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst mem_we", 64'(mem_we), 64'd0);
    check("rst mem_space", 64'(mem_space), 64'd0);
    check("rst mem_addr", 64'(mem_addr), 64'd0);
    check("rst mem_wdata", mem_wdata, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // pushq with ready held low: fields stay put, stray start ignored, done one cycle after ready.
    icode         = 4'd10;
    ValE          = 64'd40;
    ValA          = 64'h1234;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ValE  = 64'd7;
    ValA  = 64'd0;
    for (int c = 1; c <= 5; c++) begin
      check($sformatf("stall c%0d valid", c), 64'(mem_req_valid), 64'd1);
      check($sformatf("stall c%0d we", c), 64'(mem_we), 64'd1);
      check($sformatf("stall c%0d space", c), 64'(mem_space), 64'd1);
      check($sformatf("stall c%0d addr", c), 64'(mem_addr), 64'd40);
      check($sformatf("stall c%0d wdata", c), mem_wdata, 64'h1234);
      check($sformatf("stall c%0d done", c), 64'(done), 64'd0);
      start = (c == 2);
      icode = (c == 2) ? 4'd5 : 4'd10;
      if (c == 5) mem_req_ready = 1'b1;
      @(negedge clk);
    end
    check("stall done_after_ready", 64'(done), 64'd1);
    check("stall valid_dropped", 64'(mem_req_valid), 64'd0);
    @(negedge clk);
    check("stall idle_after", 64'(busy), 64'd0);
    check("stall no_queued_start", 64'(mem_req_valid), 64'd0);
    @(negedge clk);
    check("stall still_idle", 64'(busy), 64'd0);

    // Back-to-back writes with start held high: done at cycles 2 and 5.
    icode         = 4'd4;
    ValE          = 64'd16;
    ValA          = 64'd9;
    mem_req_ready = 1'b1;
    start         = 1'b1;
    done_pat      = '0;
    @(negedge clk);
    for (int c = 1; c <= 6; c++) begin
      done_pat[c] = done;
      if (c == 5) start = 1'b0;
      if (c < 6) @(negedge clk);
    end
    check("b2b done_pattern", 64'(done_pat), 64'(7'b0100100));
    check("b2b idle_after", 64'(busy), 64'd0);

    // Single-access vector table.
    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], i);
    end

    // Reset while waiting on a read, then a late response must be dropped.
    icode         = 4'd5;
    ValE          = 64'd4;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rstwait req_valid", 64'(mem_req_valid), 64'd1);
    @(negedge clk);
    check("rstwait in_wait_busy", 64'(busy), 64'd1);
    check("rstwait in_wait_valid", 64'(mem_req_valid), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst           = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 64'd555;
    check("rstwait busy", 64'(busy), 64'd0);
    check("rstwait ValM", ValM, 64'd0);
    check("rstwait dmem_error", 64'(dmem_error), 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rstwait late c%0d done", c), 64'(done), 64'd0);
      check($sformatf("rstwait late c%0d ValM", c), ValM, 64'd0);
      check($sformatf("rstwait late c%0d busy", c), 64'(busy), 64'd0);
    end
    mem_rsp_valid = 1'b0;

`ifdef MEMREQ_TIMEOUT_EN
    // Read whose response never arrives: abort after 16 stalled cycles.
    icode         = 4'd5;
    ValE          = 64'd4;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    start         = 1'b1;
    dcyc          = -1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin
        dcyc = c;
        break;
      end
      @(negedge clk);
    end
    check("timeout done_cycle", 64'(dcyc), 64'd18);
    check("timeout dmem_error", 64'(dmem_error), 64'd1);
    check("timeout ValM", ValM, 64'd0);
    @(negedge clk);
    check("timeout idle_after", 64'(busy), 64'd0);
`else
    dcyc = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
